// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, the control
// FSM state type and the packed flag bundle that travels with each result.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_PASSA = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_SRA   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Bit order (MSB..LSB): carry, zero, neg, ovf, err.
  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier. One partial product is added per
// cycle over WIDTH cycles after i_start.
//   i_start    : load operands and begin (only while idle)
//   i_a, i_b   : WIDTH-bit unsigned operands
//   o_done     : high during the final iteration cycle
//   o_product  : full 2*WIDTH-bit product, valid while o_done is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The product is handed out combinationally on the last iteration so the
  // caller can register it on the same edge that finishes the multiply.
  assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_product = w_acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU between operand issue and writeback. Accepts one operation
// per valid/ready transfer and holds a registered result plus flags until the
// consumer takes it. MUL runs on a WIDTH-cycle iterative multiplier.
//   in_valid/in_ready/op/a/b       : request side
//   out_valid/out_ready/result     : response side, flags carry..err
//   ovf_sticky/clr_sticky          : accumulated overflow indicator
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  alu_state_t         r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  alu_flags_t         r_flags;
  logic               r_sticky;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_load;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_sra;
  logic               w_big_shift;
  alu_flags_t         w_flags;
  alu_flags_t         w_mul_flags;
  logic [WIDTH-1:0]   w_ld_res;
  alu_flags_t         w_ld_flags;

  // A result being consumed this cycle may be overwritten by the new one.
  assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (op == OP_MUL);
  assign w_load      = (w_accept && (op != OP_MUL)) || w_mul_done;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // WIDTH is a power of two, so any bit above the low SHW means b >= WIDTH.
  assign w_big_shift = |(b >> SHW);
  // Kept separate so the arithmetic shift is not forced unsigned by a mux.
  assign w_sra       = $signed(a) >>> b[SHW-1:0];

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_flags = '0;
    case (op)
      OP_ADD: begin
        w_sum         = {1'b0, a} + {1'b0, b};
        w_res         = w_sum[WIDTH-1:0];
        w_flags.carry = w_sum[WIDTH];
        w_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum         = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_res         = w_sum[WIDTH-1:0];
        w_flags.carry = w_sum[WIDTH];
        w_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_PASSA: w_res = a;
      OP_PASSB: w_res = b;
      OP_SHL:   w_res = w_big_shift ? '0 : (a << b[SHW-1:0]);
      OP_SHR:   w_res = w_big_shift ? '0 : (a >> b[SHW-1:0]);
      OP_SRA:   w_res = w_big_shift ? {WIDTH{a[WIDTH-1]}} : w_sra;
      OP_MUL:   w_res = '0;
      default:  w_flags.err = 1'b1;
    endcase
    w_flags.zero = (w_res == '0);
    w_flags.neg  = w_res[WIDTH-1];
  end

  always_comb begin
    w_mul_flags       = '0;
    w_mul_flags.ovf   = |w_prod[2*WIDTH-1:WIDTH];
    w_mul_flags.zero  = (w_prod[WIDTH-1:0] == '0);
    w_mul_flags.neg   = w_prod[WIDTH-1];
  end

  assign w_ld_res   = w_mul_done ? w_prod[WIDTH-1:0] : w_res;
  assign w_ld_flags = w_mul_done ? w_mul_flags : w_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_sticky    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_mul_start) r_state <= ST_MUL;
        ST_MUL:  if (w_mul_done)  r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_ld_res;
        r_flags     <= w_ld_flags;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Setting takes priority over a simultaneous clear.
      if (w_load && w_ld_flags.ovf) r_sticky <= 1'b1;
      else if (clr_sticky)          r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign carry      = r_flags.carry;
  assign zero       = r_flags.zero;
  assign neg        = r_flags.neg;
  assign ovf        = r_flags.ovf;
  assign err        = r_flags.err;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry, zero, neg, ovf, err;
  logic         ovf_sticky;
  logic         clr_sticky;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int cyc      = 0;

  logic [W-1:0] exp_res_q[$];
  logic [4:0]   exp_fl_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .zero       (zero),
    .neg        (neg),
    .ovf        (ovf),
    .err        (err),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Flag order matches the DUT bundle: carry, zero, neg, ovf, err.
  function automatic logic [4:0] fl(input logic c, input logic z, input logic n,
                                    input logic o, input logic e);
    return {c, z, n, o, e};
  endfunction

  // Monitor: pops one expectation per delivered result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        check($sformatf("out%0d_unexpected", n_out), 32'(out_valid), 32'(0));
      end else begin
        logic [W-1:0] er;
        logic [4:0]   ef;
        er = exp_res_q.pop_front();
        ef = exp_fl_q.pop_front();
        check($sformatf("out%0d_result", n_out), 32'(result), 32'(er));
        check($sformatf("out%0d_flags", n_out), 32'({carry, zero, neg, ovf, err}), 32'(ef));
      end
      n_out++;
    end
  end

  // Drives one request starting at posedge+1, returns at posedge+1 after accept.
  task automatic issue(input logic [3:0] i_op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] er, input logic [4:0] ef, input bit push = 1'b1);
    int waited;
    waited   = 0;
    op       = i_op;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    if (push) begin
      exp_res_q.push_back(er);
      exp_fl_q.push_back(ef);
    end
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("accept_op%0d", i_op), 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int bad;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags", 32'({carry, zero, neg, ovf, err}), 32'(0));
    check("rst_sticky", 32'(ovf_sticky), 32'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Signed overflow on ADD sets the sticky flag, clr_sticky clears it
    issue(OP_ADD, 8'h7F, 8'h01, 8'h80, fl(0, 0, 1, 1, 0));
    @(negedge clk);
    check("sticky_set", 32'(ovf_sticky), 32'(1));
    @(posedge clk); #1; clr_sticky = 1'b1;
    @(posedge clk); #1; clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 32'(ovf_sticky), 32'(0));
    @(posedge clk); #1;

    // Set beats a simultaneous clear
    clr_sticky = 1'b1;
    issue(OP_SUB, 8'h80, 8'h01, 8'h7F, fl(1, 0, 0, 1, 0));
    clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", 32'(ovf_sticky), 32'(1));
    @(posedge clk); #1;

    // Back-to-back non-MUL ops, one per cycle
    c0 = cyc;
    issue(OP_SUB,   8'h00, 8'h01, 8'hFF, fl(0, 0, 1, 0, 0));
    issue(OP_SUB,   8'h05, 8'h05, 8'h00, fl(1, 1, 0, 0, 0));
    issue(OP_ADD,   8'hFF, 8'h01, 8'h00, fl(1, 1, 0, 0, 0));
    issue(OP_XOR,   8'hAA, 8'hFF, 8'h55, fl(0, 0, 0, 0, 0));
    issue(OP_OR,    8'hA0, 8'h05, 8'hA5, fl(0, 0, 1, 0, 0));
    issue(OP_PASSA, 8'h3C, 8'h00, 8'h3C, fl(0, 0, 0, 0, 0));
    issue(OP_PASSB, 8'h3C, 8'hC3, 8'hC3, fl(0, 0, 1, 0, 0));
    issue(OP_SHL,   8'h01, 8'h07, 8'h80, fl(0, 0, 1, 0, 0));
    issue(OP_SHL,   8'h03, 8'h08, 8'h00, fl(0, 1, 0, 0, 0));
    issue(OP_SHR,   8'h80, 8'h03, 8'h10, fl(0, 0, 0, 0, 0));
    issue(OP_SHR,   8'h80, 8'h09, 8'h00, fl(0, 1, 0, 0, 0));
    issue(OP_SRA,   8'h80, 8'h03, 8'hF0, fl(0, 0, 1, 0, 0));
    issue(OP_SRA,   8'h80, 8'h09, 8'hFF, fl(0, 0, 1, 0, 0));
    issue(OP_SRA,   8'h40, 8'h09, 8'h00, fl(0, 1, 0, 0, 0));
    issue(OP_SLT,   8'hFF, 8'h01, 8'h01, fl(0, 0, 0, 0, 0));
    issue(OP_SLTU,  8'hFF, 8'h01, 8'h00, fl(0, 1, 0, 0, 0));
    issue(OP_SLT,   8'h01, 8'hFF, 8'h00, fl(0, 1, 0, 0, 0));
    issue(4'd13,    8'h12, 8'h34, 8'h00, fl(0, 1, 0, 0, 1));
    issue(4'd15,    8'hFF, 8'hFF, 8'h00, fl(0, 1, 0, 0, 1));
    check("throughput_cycles", 32'(cyc - c0), 32'(19));

    // MUL latency window, operand capture at accept
    issue(OP_MUL, 8'h10, 8'h10, 8'h00, fl(0, 1, 0, 1, 0));
    a = 8'hFF; b = 8'hFF; op = OP_ADD;
    bad = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        if (out_valid || in_ready) bad++;
      end else begin
        check("mul_valid_at_w_plus_1", 32'(out_valid), 32'(1));
        check("mul_ready_low_done", 32'(in_ready), 32'(0));
      end
    end
    check("mul_busy_window", 32'(bad), 32'(0));
    @(posedge clk); #1;
    issue(OP_MUL, 8'h0F, 8'h11, 8'hFF, fl(0, 0, 1, 0, 0));

    // Backpressure: result holds, next op accepted in the draining cycle
    repeat (W + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(OP_AND, 8'hF0, 8'h3C, 8'h30, fl(0, 0, 0, 0, 0));
    op = OP_OR; a = 8'h0F; b = 8'h50; in_valid = 1'b1;
    exp_res_q.push_back(8'h5F);
    exp_fl_q.push_back(fl(0, 0, 0, 0, 0));
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(out_valid && !in_ready && result == 8'h30 &&
            {carry, zero, neg, ovf, err} == 5'b0)) bad++;
    end
    check("hold_5_cycles", 32'(bad), 32'(0));
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check("accept_on_drain", 32'(in_ready), 32'(1));
    @(posedge clk); #1; in_valid = 1'b0;

    // Reset in the middle of a MUL discards it
    repeat (3) @(posedge clk);
    #1;
    issue(OP_MUL, 8'h10, 8'h10, 8'h00, 5'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    @(negedge clk);
    check("midmul_out_valid", 32'(out_valid), 32'(0));
    check("midmul_result", 32'(result), 32'(0));
    check("midmul_flags", 32'({carry, zero, neg, ovf, err}), 32'(0));
    check("midmul_sticky", 32'(ovf_sticky), 32'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("no_stale_result", 32'(bad), 32'(0));
    check("ready_after_midmul_reset", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    issue(OP_PASSB, 8'h00, 8'h5A, 8'h5A, fl(0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_res_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It accepts one operation per transaction over a valid/ready interface and holds a registered result with flags until it is consumed. It adds shifts, unsigned compare, an iterative multiply and a sticky overflow flag. It sits between the operand-issue logic and the writeback stage of the datapath.

## Interface
- WIDTH, 8: operand/result width. Must be a power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- clk  in  1  the single clock. All state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; transfer happens when in_valid && in_ready.
- op  in  4  opcode, see Operation.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- result  out  WIDTH  registered result.
- carry, zero, neg, ovf, err  out  1 each  registered flags for the result.
- ovf_sticky  out  1  set by any delivered result with ovf=1.
- clr_sticky  in  1  synchronous clear of ovf_sticky.

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a + ~b + 1)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT signed
  - 6 PASSA
  - 7 PASSB
  - 8 SLTU
  - 9 SHL
  - 10 SHR logical
  - 11 SRA
  - 12 MUL (low WIDTH bits, unsigned)
  - 13–15 reserved
- ADD: carry is bit WIDTH of the (WIDTH+1)-bit sum. ovf = (a and b have the same sign) && (result sign differs from a).
- SUB: carry = 1 when there is no borrow (a >= b unsigned). ovf = (a and b have different signs) && (result sign differs from a).
- SLT/SLTU: result is 1 or 0 in bit 0, upper bits 0.
- Shifts: the amount is b as an unsigned value.
  - If b >= WIDTH: SHL and SHR give 0; SRA gives all copies of a[WIDTH-1].
  - Otherwise shift by b[SHW-1:0].
- MUL: shift-add, one partial product per cycle over WIDTH cycles. ovf = 1 if the full 2·WIDTH-bit product has any nonzero upper half.
- Reserved opcodes: result 0, err=1, zero=1. All other ops give err=0.
- carry and ovf are 0 for every op except those defined above.
- zero = (result == 0). neg = result[WIDTH-1].
- FSM states:
  - IDLE → MUL on accept with op=12.
  - MUL → DONE after WIDTH iterations, loading the output registers.
  - All other accepted ops load the output registers directly from IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A new result may overwrite a result that is being consumed in the same cycle.
- ovf_sticky: set on the cycle a result with ovf=1 is loaded. If clr_sticky is asserted in the same cycle, set wins.

## Timing
- Reset values: out_valid=0, result=0, all flags=0, ovf_sticky=0, state=IDLE, in_ready=1 after reset deasserts.
- Non-MUL op accepted in cycle t: out_valid=1 from cycle t+1.
- MUL accepted in cycle t: out_valid=1 from cycle t+WIDTH+1. in_ready=0 for cycles t+1 through t+WIDTH+1 if not yet drained.
- While out_valid=1 && out_ready=0: result and flags hold stable.
- Back-to-back throughput for non-MUL ops with out_ready=1: one result per cycle.
- Reset mid-MUL: the operation is discarded, no result is emitted, state returns to IDLE.
- Operands are captured at accept. Input changes afterwards have no effect.

## Structure
- Package alu_pipe_pkg:
  - opcode localparams OP_ADD … OP_MUL
  - FSM state enum (IDLE, MUL, DONE)
  - flag bundle typedef
- Sub-module alu_mul_seq: iterative WIDTH-cycle unsigned multiplier with start/done handshake, producing the 2·WIDTH-bit product.
- The combinational op decode stays in alu_pipe.

## Test plan
1. WIDTH=8, ADD a=0x7F, b=0x01 → result 0x80, carry=0, ovf=1, neg=1, zero=0, ovf_sticky=1 on the next cycle. Then clr_sticky → ovf_sticky=0.
2. SUB a=0x00, b=0x01 → result 0xFF, carry=0, ovf=0, neg=1. SUB a=0x05, b=0x05 → result 0x00, carry=1, zero=1.
3. MUL a=0x10, b=0x10 accepted at cycle 0 → out_valid at cycle 9, result 0x00, zero=1, ovf=1. MUL 0x0F×0x11 → 0xFF, ovf=0. in_ready=0 throughout the multiply.
4. SRA a=0x80, b=3 → 0xF0. SHR a=0x80, b=9 → 0x00. SRA a=0x80, b=9 → 0xFF. SLT a=0xFF, b=0x01 → 1. SLTU with the same operands → 0.
5. Hold out_ready=0, issue AND 0xF0&0x3C → result 0x30 held, in_ready=0 for 5 cycles. Raise out_ready → 0x30 consumed and the next op is accepted in the same cycle.
6. Reserved op=13 → result 0, err=1, zero=1. Assert rst_n=0 at cycle 4 of a MUL → out_valid=0, all outputs 0, no stale result after release.
